reg_spill_engine: RTL
=====================

// Module: reg_spill_engine
// PURPOSE
//  Context save/restore initiator for the 4x8 register file: on request, reads every
//  register out through the file's async read port A and stores it to data memory, or
//  loads a saved image from memory and writes it back through the file's write port.
//  Sits beside the core; the core stalls while busy=1 and muxes this block onto the
//  register file's r_a / write port and onto the data-memory port.
// PARAMETERS
//  NUM_REGS   4  registers transferred (indices 0..NUM_REGS-1)
//  REG_IDX_W  2  register index width, clog2(NUM_REGS)
//  DATA_W     8  register / memory data width
//  ADDR_W     8  data-memory address width
// PORTS
//  clk            in   1          clock, rising edge
//  reset          in   1          asynchronous, active-high
//  start_save     in   1          pulse: save regs to memory at base_addr
//  start_restore  in   1          pulse: load regs from memory at base_addr
//  base_addr      in   ADDR_W     image base; slot i at base_addr+i
//  busy           out  1          transfer in progress
//  done           out  1          one-cycle pulse after the last transfer
//  rf_r_a         out  REG_IDX_W  register file read index A
//  rf_data_a      in   DATA_W     register file async read data A
//  rf_write_en    out  1          register file write enable
//  rf_write_reg   out  REG_IDX_W  register file write index
//  rf_write_value out  DATA_W     register file write data
//  mem_addr       out  ADDR_W     data-memory address
//  mem_we         out  1          data-memory write enable
//  mem_wdata      out  DATA_W     data-memory write data
//  mem_re         out  1          data-memory read enable (sync read, 1-cycle latency)
//  mem_rdata      in   DATA_W     data-memory read data, valid cycle after mem_re
// BEHAVIOUR
//  - FSM states IDLE, SAVE, RESTORE. Reset -> IDLE; all outputs 0; counters, pending-read
//    flag cleared. Reset mid-transfer aborts immediately; in-flight read data is dropped.
//  - Starts sampled only in IDLE; ignored while busy. Both high same edge: save wins.
//    base_addr latched at the accepting edge; later changes have no effect.
//  - busy=1 in SAVE/RESTORE, 0 in IDLE. done is registered: high for the one cycle
//    after the final transfer, coinciding with IDLE; a new start is accepted that cycle.
//  - SAVE: idx 0..NUM_REGS-1, one per cycle: rf_r_a=idx, mem_we=1, mem_addr=base+idx,
//    mem_wdata=rf_data_a (combinational pass-through). NUM_REGS busy cycles.
//  - RESTORE: issue cycle k (k=0..NUM_REGS-1): mem_re=1, mem_addr=base+k. Write cycle
//    k+1: rf_write_en=1, rf_write_reg=k, rf_write_value=mem_rdata. Issue and write
//    overlap; NUM_REGS+1 busy cycles; last cycle writes only (mem_re=0).
//  - Address arithmetic modulo 2^ADDR_W (base=0xFE, 4 regs -> FE,FF,00,01).
//  - Outside active transfer cycles: mem_we, mem_re, rf_write_en = 0; rf_r_a,
//    rf_write_reg, mem_addr, mem_wdata, rf_write_value = 0.
//  - Never asserts mem_we and mem_re together; never writes the register file in SAVE.
// CONFIGURATION
//  SPILL_MASK_EN defined: adds input reg_mask [NUM_REGS-1:0], latched with base_addr.
//    Index i with mask bit 0 keeps its cycle and address slot but drives no mem_we
//    (save) / no mem_re and no rf_write_en (restore). Latency unchanged. Mask all-zero:
//    full-length run, no strobes, done still pulses.
//  Not defined: no reg_mask port; all NUM_REGS registers always transferred.
// TESTING
//  1 Regs {11,22,33,44}, start_save base=0x40 -> mem[40..43]={11,22,33,44}, busy 4 cyc,
//    done 1 cyc after last write.
//  2 mem[80..83]={A1,B2,C3,D4}, start_restore base=0x80 -> regs {A1,B2,C3,D4}, busy 5
//    cyc, rf_write_en exactly 4 cyc, first write 1 cyc after first mem_re.
//  3 Save base=0xFE -> writes at FE,FF,00,01; restore from 0xFE round-trips all regs.
//  4 start_save and start_restore same edge -> save only; start_restore pulse while busy
//    -> ignored, no extra mem_re; start on done cycle -> accepted.
//  5 Assert reset at restore cycle 2 -> outputs 0 same cycle, regs 2..3 not written,
//    busy=0, no done; next start_save runs normally.
//  6 SPILL_MASK_EN, mask=4'b0101, save base=0x10 -> mem_we only at 0x10 and 0x12,
//    busy still 4 cyc; restore with same mask writes only r0, r2.

Source files
------------

// File: rtl/reg_spill_engine_if.sv
// Bundle between the register spill engine and the core/register-file/data-memory side:
// start controls and image base in; busy/done status out; register file read port A and
// write port; single data-memory port (sync read, 1-cycle latency).
// Ports (signals): start_save, start_restore, base_addr, [reg_mask], busy, done,
//   rf_r_a, rf_data_a, rf_write_en, rf_write_reg, rf_write_value,
//   mem_addr, mem_we, mem_wdata, mem_re, mem_rdata.
// master = the engine (drives register-file and memory strobes); slave = the core side.
// SPILL_MASK_EN adds reg_mask (per-register transfer enable).
interface reg_spill_engine_if #(
  parameter int NUM_REGS  = 4,
  parameter int REG_IDX_W = 2,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8
);

  logic                 start_save;
  logic                 start_restore;
  logic [ADDR_W-1:0]    base_addr;
`ifdef SPILL_MASK_EN
  logic [NUM_REGS-1:0]  reg_mask;
`endif
  logic                 busy;
  logic                 done;

  logic [REG_IDX_W-1:0] rf_r_a;
  logic [DATA_W-1:0]    rf_data_a;
  logic                 rf_write_en;
  logic [REG_IDX_W-1:0] rf_write_reg;
  logic [DATA_W-1:0]    rf_write_value;

  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_we;
  logic [DATA_W-1:0]    mem_wdata;
  logic                 mem_re;
  logic [DATA_W-1:0]    mem_rdata;

`ifdef SPILL_MASK_EN
  modport master (
    input  start_save, start_restore, base_addr, reg_mask, rf_data_a, mem_rdata,
    output busy, done, rf_r_a, rf_write_en, rf_write_reg, rf_write_value,
           mem_addr, mem_we, mem_wdata, mem_re
  );
  modport slave (
    output start_save, start_restore, base_addr, reg_mask, rf_data_a, mem_rdata,
    input  busy, done, rf_r_a, rf_write_en, rf_write_reg, rf_write_value,
           mem_addr, mem_we, mem_wdata, mem_re
  );
`else
  modport master (
    input  start_save, start_restore, base_addr, rf_data_a, mem_rdata,
    output busy, done, rf_r_a, rf_write_en, rf_write_reg, rf_write_value,
           mem_addr, mem_we, mem_wdata, mem_re
  );
  modport slave (
    output start_save, start_restore, base_addr, rf_data_a, mem_rdata,
    input  busy, done, rf_r_a, rf_write_en, rf_write_reg, rf_write_value,
           mem_addr, mem_we, mem_wdata, mem_re
  );
`endif

endinterface

// File: rtl/reg_spill_engine.sv
// Purpose: context save/restore initiator; spills every register of the file to data
//   memory at base_addr+i, or reloads a saved image from memory into the register file.
// Latency: save = NUM_REGS busy cycles, restore = NUM_REGS+1 busy cycles; done pulses the
//   cycle after the last transfer (already back in IDLE, so a new start is taken there).
// Backpressure: none on the memory/register-file side; starts are ignored while busy.
// Ports: clk, reset (async, active-high), bus (reg_spill_engine_if.master):
//   start_save/start_restore/base_addr[/reg_mask] in, busy/done out,
//   rf_r_a/rf_data_a (async read port A), rf_write_en/_reg/_value (write port),
//   mem_addr/mem_we/mem_wdata/mem_re/mem_rdata (sync-read data memory).
// Optional feature: SPILL_MASK_EN adds a per-register mask latched with base_addr; masked
//   indices keep their cycle and address slot but raise no strobes.
module reg_spill_engine #(
  parameter int NUM_REGS  = 4,
  parameter int REG_IDX_W = 2,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8
) (
  input logic                 clk,
  input logic                 reset,
  reg_spill_engine_if.master  bus
);

  // Counter must reach NUM_REGS for the trailing write-only restore cycle.
  localparam int CNT_W = $clog2(NUM_REGS + 1);
  localparam logic [CNT_W-1:0] LAST_SAVE    = CNT_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] LAST_RESTORE = CNT_W'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic                 pend_q, pend_d;          // a memory read was issued last cycle
  logic [REG_IDX_W-1:0] pend_idx_q, pend_idx_d;  // register that read belongs to
  logic                 done_q, done_d;
  logic [NUM_REGS-1:0]  mask_eff;

  logic [REG_IDX_W-1:0] idx;
  logic [ADDR_W-1:0]    slot_addr;

  logic                 rf_write_en_o;
  logic [REG_IDX_W-1:0] rf_write_reg_o;
  logic [DATA_W-1:0]    rf_write_value_o;
  logic [REG_IDX_W-1:0] rf_r_a_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic                 mem_we_o;
  logic [DATA_W-1:0]    mem_wdata_o;
  logic                 mem_re_o;

`ifdef SPILL_MASK_EN
  logic [NUM_REGS-1:0]  mask_q, mask_d;
  assign mask_eff = mask_q;
`else
  assign mask_eff = '1;
`endif

  assign idx       = cnt_q[REG_IDX_W-1:0];
  // Address wraps naturally at 2^ADDR_W.
  assign slot_addr = base_q + ADDR_W'(cnt_q);

  // State and bookkeeping registers. Reset drops any in-flight read result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      done_q     <= 1'b0;
`ifdef SPILL_MASK_EN
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      done_q     <= done_d;
`ifdef SPILL_MASK_EN
      mask_q     <= mask_d;
`endif
    end
  end

  // Next-state and output decode. All port outputs are zero unless a transfer cycle
  // drives them, so the core's muxes see clean zeros while idle.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    base_d           = base_q;
    pend_d           = 1'b0;
    pend_idx_d       = '0;
    done_d           = 1'b0;
`ifdef SPILL_MASK_EN
    mask_d           = mask_q;
`endif
    rf_r_a_o         = '0;
    rf_write_en_o    = 1'b0;
    rf_write_reg_o   = '0;
    rf_write_value_o = '0;
    mem_addr_o       = '0;
    mem_we_o         = 1'b0;
    mem_wdata_o      = '0;
    mem_re_o         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Save has priority when both starts arrive on the same edge.
        if (bus.start_save || bus.start_restore) begin
          state_d = bus.start_save ? SAVE : RESTORE;
          cnt_d   = '0;
          base_d  = bus.base_addr;
`ifdef SPILL_MASK_EN
          mask_d  = bus.reg_mask;
`endif
        end
      end

      SAVE: begin
        // Register file read is asynchronous, so the data goes straight to memory.
        rf_r_a_o   = idx;
        mem_addr_o = slot_addr;
        if (mask_eff[idx]) begin
          mem_we_o    = 1'b1;
          mem_wdata_o = bus.rf_data_a;
        end
        if (cnt_q == LAST_SAVE) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESTORE: begin
        // Issue slot k and write back slot k-1 in the same cycle; the extra final
        // cycle only retires the last read.
        if (cnt_q != LAST_RESTORE) begin
          mem_addr_o = slot_addr;
          mem_re_o   = mask_eff[idx];
          pend_d     = mask_eff[idx];
          pend_idx_d = idx;
        end
        if (pend_q) begin
          rf_write_en_o    = 1'b1;
          rf_write_reg_o   = pend_idx_q;
          rf_write_value_o = bus.mem_rdata;
        end
        if (cnt_q == LAST_RESTORE) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.busy           = (state_q != IDLE);
  assign bus.done           = done_q;
  assign bus.rf_r_a         = rf_r_a_o;
  assign bus.rf_write_en    = rf_write_en_o;
  assign bus.rf_write_reg   = rf_write_reg_o;
  assign bus.rf_write_value = rf_write_value_o;
  assign bus.mem_addr       = mem_addr_o;
  assign bus.mem_we         = mem_we_o;
  assign bus.mem_wdata      = mem_wdata_o;
  assign bus.mem_re         = mem_re_o;

  // The single memory port cannot read and write in one cycle.
  a_no_we_re: assert property (@(posedge clk) disable iff (reset) !(mem_we_o && mem_re_o));
  // A save must never disturb the register file.
  a_no_rf_write_in_save: assert property (@(posedge clk) disable iff (reset)
                                          !(state_q == SAVE && rf_write_en_o));

endmodule
